musical_score_recorder: RTL and testbench
=========================================

MUSICAL_SCORE_RECORDER -- requirements
Module: musical_score_recorder

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `reset`; reset SHALL be synchronous and active-low (asserted when `reset`=0).
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse to begin a recording
- stop  in  1  one-cycle pulse to end a recording
- tempo  in  26  beat period minus one, in clk cycles
- played_note  in  4  detected note code
- note_valid  in  1  `played_note` is meaningful
- wr_en  out  1  score RAM write strobe
- wr_addr  out  8  score RAM address
- wr_data  out  4  score RAM note code
- recording  out  1  high while notes are being captured
- song_length  out  8  notes written, excluding the terminator
- done  out  1  high once the terminator has been written
- overflow  out  1  the last recording hit capacity

Function
REQ-003 Note codes SHALL be 4 bits: 0000 = rest; 1111 = end-of-song terminator, which is reserved.
REQ-004 The FSM SHALL have the states IDLE, LEAD_IN, RECORD, TERMINATE and DONE.
REQ-005 IDLE→RECORD (or →LEAD_IN, see REQ-017) SHALL occur on `start`.
REQ-006 On entering RECORD or LEAD_IN, the block SHALL clear the beat counter, the write pointer, `overflow` and `done`.
REQ-007 The beat counter SHALL increment every cycle outside IDLE/DONE and SHALL pulse `beat` for one cycle when count==`tempo`, then clear to 0.
- Beat period SHALL be `tempo`+1 cycles.
- `tempo`=0 SHALL give a beat every cycle.
REQ-008 On each `beat` in RECORD, the block SHALL assert `wr_en` for one cycle with `wr_addr`=ptr and `wr_data` = (`note_valid` ? `played_note` : 0000), then increment ptr.
REQ-009 A sampled `played_note` of 1111 SHALL be written as 0000.
REQ-010 Writes SHALL occur only on beats and in TERMINATE; `wr_en` SHALL be 0 at all other times.
REQ-011 If ptr reaches 255 in RECORD, the block SHALL set `overflow`=1 and enter TERMINATE, so that address 255 holds the terminator; 255 notes is the maximum.
REQ-012 `stop` in RECORD SHALL cause a transition to TERMINATE.
- If `beat` occurs in the same cycle, that note SHALL be written first and the terminator SHALL go at ptr+1.
REQ-013 In TERMINATE, the block SHALL spend exactly one cycle: `wr_en`=1, `wr_addr`=ptr, `wr_data`=1111, `song_length`<=ptr; it SHALL then go to DONE.
REQ-014 DONE SHALL hold `done`=1, `song_length` and `overflow` until `start`, which SHALL restart as from IDLE.
REQ-015 `start` SHALL be ignored in LEAD_IN, RECORD and TERMINATE.
- `stop` SHALL be ignored in IDLE, TERMINATE and DONE.
REQ-016 `recording` SHALL be 1 only in RECORD.

Configuration
REQ-017 Macro `SCORE_LEAD_IN_EN` SHALL control the count-in:
- Defined: `start` SHALL enter LEAD_IN, which counts 16 beats with no writes and then enters RECORD with the counter cleared. This matches the 16-slot player lookahead window.
- `stop` in LEAD_IN SHALL go to TERMINATE (terminator at address 0, `song_length`=0).
- Undefined: LEAD_IN SHALL be unreachable and `start` SHALL go directly to RECORD.

Reset
REQ-018 When `reset`=0 at a clk edge, the block SHALL enter IDLE.
- Outputs SHALL be `wr_en`=0, `wr_addr`=0, `wr_data`=0, `recording`=0, `song_length`=0, `done`=0, `overflow`=0.
- The beat counter and ptr SHALL be 0.
REQ-019 Reset SHALL override all inputs in any state, including mid-recording; no terminator SHALL be written.

Verification
REQ-020 The bench SHALL cover these directed scenarios (macro undefined unless noted):
- `tempo`=3, `start`, notes 0101,0011,0111 valid on three beats, then `stop` → writes at cycles 4,8,12 to addresses 0..2; 1111 at address 3; `song_length`=3; `done`=1.
- `note_valid`=0 on the second beat and `played_note`=1111 on the third → addresses 1 and 2 hold 0000.
- `tempo`=0, `note_valid` held high, no `stop` → 255 writes, 1111 at address 255, `overflow`=1, `song_length`=255.
- `stop` coincident with beat 2 (ptr=1) → note at address 1, 1111 at address 2, `song_length`=2.
- `reset`=0 mid-RECORD at ptr=5 → all outputs 0, IDLE, no further `wr_en`; a subsequent `start` writes from address 0.
- `SCORE_LEAD_IN_EN` defined, `tempo`=1 → first `wr_en` at beat 17 (cycle 34 after `start`); `recording` rises after beat 16.

Source files
------------

// File: rtl/musical_score_recorder.sv
// rtl/musical_score_recorder.sv - beat-quantised note recorder writing a 1111-terminated score to RAM
// Optional count-in of 16 beats before capture: define SCORE_LEAD_IN_EN.
module musical_score_recorder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [25:0] tempo,
  input  logic [3:0]  played_note,
  input  logic        note_valid,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [3:0]  wr_data,
  output logic        recording,
  output logic [7:0]  song_length,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, LEAD_IN, RECORD, TERMINATE, DONE} state_t;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

`ifdef SCORE_LEAD_IN_EN
  localparam state_t START_STATE = LEAD_IN;
`else
  localparam state_t START_STATE = RECORD;
`endif

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  len_q, len_d;
  logic [3:0]  lead_q, lead_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        active;
  logic        beat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    lead_d  = lead_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_data = NOTE_REST;

    active = (state_q != IDLE) && (state_q != DONE);
    beat   = active && (cnt_q == tempo);

    if (active) begin
      cnt_d = beat ? 26'd0 : cnt_q + 26'd1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = START_STATE;
          cnt_d   = 26'd0;
          ptr_d   = 8'd0;
          lead_d  = 4'd0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      LEAD_IN: begin
        // Leaving on the 16th beat also clears the counter, so RECORD starts on a fresh beat.
        if (stop) begin
          state_d = TERMINATE;
        end else if (beat) begin
          lead_d = lead_q + 4'd1;
          if (lead_q == 4'd15) begin
            state_d = RECORD;
          end
        end
      end
      RECORD: begin
        if (beat) begin
          wr_en   = 1'b1;
          wr_data = (note_valid && (played_note != NOTE_END)) ? played_note : NOTE_REST;
          ptr_d   = ptr_q + 8'd1;
          // Address 255 is kept for the terminator.
          if (ptr_q == 8'd254) begin
            ovf_d   = 1'b1;
            state_d = TERMINATE;
          end
        end
        if (stop) begin
          state_d = TERMINATE;
        end
      end
      TERMINATE: begin
        wr_en   = 1'b1;
        wr_data = NOTE_END;
        len_d   = ptr_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 26'd0;
      ptr_q   <= 8'd0;
      len_q   <= 8'd0;
      lead_q  <= 4'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      lead_q  <= lead_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr     = ptr_q;
  assign recording   = (state_q == RECORD);
  assign song_length = len_q;
  assign done        = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_musical_score_recorder.sv
// tb/tb_musical_score_recorder.sv - directed self-checking bench for musical_score_recorder
module tb_musical_score_recorder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [25:0] tempo = 26'd0;
  logic [3:0]  played_note = 4'h0;
  logic        note_valid = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        recording;
  logic [7:0]  song_length;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwr = 0;
  int s0;
  int base;
  logic [3:0] mem [256];
  int wcyc [256];

  musical_score_recorder dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .tempo(tempo),
    .played_note(played_note), .note_valid(note_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .recording(recording),
    .song_length(song_length), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behaves as the score RAM.
  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr]  = wr_data;
      wcyc[wr_addr] = cyc;
      nwr           = nwr + 1;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    s0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_recording", recording, 0);
    check("rst_song_length", song_length, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    tick(2);

`ifdef SCORE_LEAD_IN_EN
    tempo = 26'd1; note_valid = 1'b1; played_note = 4'h4;
    base = nwr;
    do_start();
    for (int i = 0; i < 100 && !recording; i++) tick();
    check("li_rec_rise_cycle", cyc - s0, 33);
    check("li_no_writes", nwr - base, 0);
    tick();
    check("li_first_wr_cycle", cyc - s0, 34);
    check("li_first_wr_en", wr_en, 1);
    check("li_first_wr_addr", wr_addr, 0);
    check("li_first_wr_data", wr_data, 4);
    stop = 1'b1; tick(); stop = 1'b0;
    tick(2);
    check("li_len1", song_length, 1);
    do_start();
    tick(3);
    check("li_lead_recording", recording, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("li_stop_wr_en", wr_en, 1);
    check("li_stop_wr_addr", wr_addr, 0);
    check("li_stop_wr_data", wr_data, 15);
    tick();
    check("li_stop_done", done, 1);
    check("li_stop_len", song_length, 0);
`else
    // Three notes at tempo 3, then stop.
    tempo = 26'd3; note_valid = 1'b1; played_note = 4'h5;
    base = nwr;
    do_start();
    check("s1_recording", recording, 1);
    tick(4); played_note = 4'h3;
    tick(4); played_note = 4'h7;
    tick(4); stop = 1'b1;
    tick(); stop = 1'b0;
    check("s1_term_wr_en", wr_en, 1);
    check("s1_term_addr", wr_addr, 3);
    check("s1_term_data", wr_data, 15);
    tick();
    check("s1_done", done, 1);
    check("s1_len", song_length, 3);
    check("s1_ovf", overflow, 0);
    check("s1_rec_off", recording, 0);
    check("s1_mem0", mem[0], 5);
    check("s1_mem1", mem[1], 3);
    check("s1_mem2", mem[2], 7);
    check("s1_mem3", mem[3], 15);
    check("s1_cyc0", wcyc[0] - s0, 4);
    check("s1_cyc1", wcyc[1] - s0, 8);
    check("s1_cyc2", wcyc[2] - s0, 12);
    check("s1_nwr", nwr - base, 4);
    tick(3);
    check("s1_done_hold", done, 1);

    // Invalid note and reserved code are written as rests.
    played_note = 4'h5; note_valid = 1'b1;
    do_start();
    check("s2_done_clr", done, 0);
    tick(4); note_valid = 1'b0;
    tick(4); note_valid = 1'b1; played_note = 4'hF;
    tick(4); stop = 1'b1;
    tick(); stop = 1'b0;
    tick();
    check("s2_mem0", mem[0], 5);
    check("s2_mem1", mem[1], 0);
    check("s2_mem2", mem[2], 0);
    check("s2_mem3", mem[3], 15);
    check("s2_len", song_length, 3);

    // Capacity: beat every cycle until the RAM is full.
    tempo = 26'd0; played_note = 4'h9; note_valid = 1'b1;
    base = nwr;
    do_start();
    for (int i = 0; i < 400 && !done; i++) tick();
    check("s3_done", done, 1);
    check("s3_ovf", overflow, 1);
    check("s3_len", song_length, 255);
    check("s3_mem254", mem[254], 9);
    check("s3_mem255", mem[255], 15);
    check("s3_nwr", nwr - base, 256);

    // Stop on the same cycle as beat 2.
    tempo = 26'd3; played_note = 4'h2;
    do_start();
    check("s4_ovf_clr", overflow, 0);
    tick(4); played_note = 4'h6;
    tick(3);
    check("s4_beat2_wr_en", wr_en, 1);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("s4_term_addr", wr_addr, 2);
    tick();
    check("s4_mem0", mem[0], 2);
    check("s4_mem1", mem[1], 6);
    check("s4_mem2", mem[2], 15);
    check("s4_len", song_length, 2);

    // Reset while recording.
    tempo = 26'd0;
    do_start();
    tick(5);
    check("s5_ptr5", wr_addr, 5);
    reset = 1'b0;
    tick();
    check("s5_wr_en", wr_en, 0);
    check("s5_wr_addr", wr_addr, 0);
    check("s5_wr_data", wr_data, 0);
    check("s5_recording", recording, 0);
    check("s5_len", song_length, 0);
    check("s5_done", done, 0);
    check("s5_ovf", overflow, 0);
    reset = 1'b1;
    base = nwr;
    tick(10);
    check("s5_no_writes", nwr - base, 0);
    played_note = 4'hA;
    do_start();
    check("s5_restart_wr_en", wr_en, 1);
    check("s5_restart_addr", wr_addr, 0);
    check("s5_restart_data", wr_data, 10);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("s5_restart_len", song_length, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
